ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It takes decoded M-extension operations and operands from ID/EX and computes the result over multiple cycles. While it works it raises a stall to the hazard unit, which holds F/D/E and keeps ID/EX frozen. A one-cycle `done` marks the cycle in which `result` is valid for the EX/MEM register.

---
 rtl/ex_muldiv_pkg.sv | 29 ++
 rtl/ex_muldiv_if.sv | 16 +
 rtl/ex_muldiv_step.sv | 35 +++
 rtl/ex_muldiv.sv | 184 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// MULDIV_FAST_MUL_EN (see ex_muldiv.sv) selects a single-cycle multiplier.
package ex_muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN);

  // funct3 encodings of the M-extension ops
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] DIV0_QUOT = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] OVF_QUOT  = INT_MIN;
  localparam logic [XLEN-1:0] OVF_REM   = {XLEN{1'b0}};

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX-side request and EX/MEM-side response bundle of the mul/div unit.
interface ex_muldiv_if;
  import ex_muldiv_pkg::*;

  logic            flush;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output flush, start, op, a, b, input  busy, done, result);
  modport slave  (input  flush, start, op, a, b, output busy, done, result);
endinterface

// File: rtl/ex_muldiv_step.sv
// One iteration of the shared datapath: a shift-add multiply step or a
// restoring-divide step on the {hi, lo} working pair.
module muldiv_step
  import ex_muldiv_pkg::*;
(
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);
  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Multiply: hi accumulates, lo holds the multiplier and collects low product bits.
  // Divide:   hi is the partial remainder, lo shifts the dividend out and quotient in.
  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    rem_sh = {hi, lo[XLEN-1]};
    diff   = rem_sh - {1'b0, opnd};
    hi_nxt = sum[XLEN:1];
    lo_nxt = {sum[0], lo[XLEN-1:1]};
    if (is_div) begin
      if (!diff[XLEN]) begin
        hi_nxt = diff[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = rem_sh[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Define MULDIV_FAST_MUL_EN to compute multiplies in a single cycle.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  ex_muldiv_if.slave io
);
  localparam int unsigned PW = 2 * XLEN;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  opnd_q, opnd_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             done_q, done_d;
  logic             busy_c;

  logic             a_signed, b_signed, a_neg, b_neg;
  logic             div_zero, div_ovf;
  logic [XLEN-1:0]  a_mag, b_mag;

  // Decode of the incoming op: signedness, magnitudes and special cases
  always_comb begin
    a_signed = (io.op == OP_MULH) || (io.op == OP_MULHSU) ||
               (io.op == OP_DIV)  || (io.op == OP_REM);
    b_signed = (io.op == OP_MULH) || (io.op == OP_DIV) || (io.op == OP_REM);
    a_neg    = a_signed && io.a[XLEN-1];
    b_neg    = b_signed && io.b[XLEN-1];
    a_mag    = a_neg ? -io.a : io.a;
    b_mag    = b_neg ? -io.b : io.b;
    div_zero = io.op[2] && (io.b == '0);
    div_ovf  = ((io.op == OP_DIV) || (io.op == OP_REM)) &&
               (io.a == INT_MIN) && (io.b == {XLEN{1'b1}});
  end

  logic [XLEN-1:0] hi_nxt, lo_nxt;

  muldiv_step u_step (
    .is_div (op_q[2]),
    .hi     (hi_q),
    .lo     (lo_q),
    .opnd   (opnd_q),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  logic [PW-1:0]   prod, prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, calc_res;

  // Sign correction applied to the output of the final iteration
  always_comb begin
    prod     = {hi_nxt, lo_nxt};
    prod_fix = neg_q ? -prod : prod;
    quot_fix = neg_q ? -lo_nxt : lo_nxt;
    rem_fix  = neg_rem_q ? -hi_nxt : hi_nxt;
    if (op_q[2]) begin
      calc_res = op_q[1] ? rem_fix : quot_fix;
    end else begin
      calc_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [PW-1:0]   fast_prod;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    fast_prod = {{XLEN{a_neg}}, io.a} * {{XLEN{b_neg}}, io.b};
    fast_res  = (io.op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[PW-1:XLEN];
  end
`endif

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    result_d  = result_q;
    done_d    = 1'b0;
    busy_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (io.start && !io.flush) begin
          busy_c    = 1'b1;
          op_d      = io.op;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          hi_d      = '0;
          lo_d      = a_mag;
          opnd_d    = b_mag;
          cnt_d     = '0;
          if (div_zero) begin
            result_d = io.op[1] ? io.a : DIV0_QUOT;
            done_d   = 1'b1;
            state_d  = ST_DONE;
          end else if (div_ovf) begin
            result_d = io.op[1] ? OVF_REM : OVF_QUOT;
            done_d   = 1'b1;
            state_d  = ST_DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!io.op[2]) begin
            result_d = fast_res;
            done_d   = 1'b1;
            state_d  = ST_DONE;
`endif
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        busy_c = 1'b1;
        hi_d   = hi_nxt;
        lo_d   = lo_nxt;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          result_d = calc_res;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A redirect abandons the op and leaves the previous result in place
    if (io.flush) begin
      state_d  = ST_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end

    if (reset) begin
      busy_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign io.busy   = busy_c;
  assign io.done   = done_q;
  assign io.result = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomised self-checking bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;
  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_muldiv_if io();

  ex_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic            chk_en = 1'b0;
  logic            exp_busy;
  logic            exp_done;
  logic [XLEN-1:0] exp_result;
  logic [XLEN-1:0] prev_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V M-extension semantics from plain integer arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] sa64, sb64, ua64, ub64, p;
    int sa, sb;
    logic ovf;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ua64 = {32'b0, a};
    ub64 = {32'b0, b};
    sa   = a;
    sb   = b;
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua64 * ub64; return p[31:0]; end
      3'd1: begin p = sa64 * sb64; return p[63:32]; end
      3'd2: begin p = sa64 * ub64; return p[63:32]; end
      3'd3: begin p = ua64 * ub64; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles from start to the done pulse
  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return XLEN + 1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",   32'(io.busy), 32'(exp_busy));
      check("done",   32'(io.done), 32'(exp_done));
      check("result", io.result,    exp_result);
    end
  end

  // Issue one op (start held through DONE); flush_at >= 0 aborts in that cycle
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at);
    int lat;
    logic [31:0] res;
    lat = lat_of(op, a, b);
    res = ref_result(op, a, b);
    for (int c = 0; c <= lat; c++) begin
      if (flush_at >= 0 && c > flush_at) break;
      io.start = 1'b1;
      io.op    = op;
      io.a     = a;
      io.b     = b;
      io.flush = (c == flush_at);
      exp_busy = (c == flush_at && c == 0) ? 1'b0 : (c < lat);
      exp_done = (c == lat);
      if (c == lat) prev_res = res;
      exp_result = prev_res;
      @(posedge clk); #1;
    end
    if (flush_at >= 0) begin
      io.start   = 1'b0;
      io.flush   = 1'b0;
      exp_busy   = 1'b0;
      exp_done   = 1'b0;
      exp_result = prev_res;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      io.start   = 1'b0;
      io.flush   = 1'b0;
      io.op      = 3'($urandom_range(0, 7));
      io.a       = $urandom;
      io.b       = $urandom;
      exp_busy   = 1'b0;
      exp_done   = 1'b0;
      exp_result = prev_res;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    int          r_fl;

    // Reference model pinned to hand-computed values
    check("pin_mul",    ref_result(3'd0, 32'd7, 32'hFFFF_FFFD),          32'hFFFF_FFEB);
    check("pin_mulhu",  ref_result(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF),  32'hFFFF_FFFE);
    check("pin_mulh",   ref_result(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF),  32'h0);
    check("pin_mulhsu", ref_result(3'd2, 32'hFFFF_FFFF, 32'd2),          32'hFFFF_FFFF);
    check("pin_div",    ref_result(3'd4, 32'hFFFF_FFF9, 32'd2),          32'hFFFF_FFFD);
    check("pin_rem",    ref_result(3'd6, 32'hFFFF_FFF9, 32'd2),          32'hFFFF_FFFF);
    check("pin_divu",   ref_result(3'd5, 32'd100, 32'd7),                32'd14);

    // Reset with start high: no stall, no done, result cleared
    reset    = 1'b1;
    io.start = 1'b1;
    io.flush = 1'b0;
    io.op    = 3'd4;
    io.a     = 32'd7;
    io.b     = 32'd2;
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_busy",   32'(io.busy), 32'd0);
      check("rst_done",   32'(io.done), 32'd0);
      check("rst_result", io.result,    32'd0);
    end
    @(posedge clk); #1;
    reset    = 1'b0;
    prev_res = '0;
    chk_en   = 1'b1;
    idle(2);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, -1);
    check("dut_mul", io.result, 32'hFFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("dut_mulhu", io.result, 32'hFFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("dut_mulh", io.result, 32'h0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, -1);
    check("dut_div", io.result, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, -1);
    check("dut_rem", io.result, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd5, 32'd0, -1);
    check("dut_divu0", io.result, 32'hFFFF_FFFF);
    run_op(3'd6, 32'd5, 32'd0, -1);
    check("dut_rem0", io.result, 32'd5);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("dut_divovf", io.result, 32'h8000_0000);
    run_op(3'd4, 32'd1000, 32'd3, 10);
    check("dut_flush_hold", io.result, 32'h8000_0000);
    run_op(3'd5, 32'd100, 32'd7, -1);
    check("dut_divu", io.result, 32'd14);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("dut_removf", io.result, 32'h0);
    idle(1);

    // Random ops, some back-to-back, with corner operands and occasional flushes
    for (int i = 0; i < 60; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = 32'h0;
        1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        2: r_b = 32'($urandom_range(1, 15));
        3: r_a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      r_fl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, lat_of(r_op, r_a, r_b) - 1) : -1;
      run_op(r_op, r_a, r_b, r_fl);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
